// File: rtl/crc8_engine.sv
// CRC-8 engine: accepts one byte at a time and shifts it MSB-first through
// the CRC register, one bit per clock. At the end of a frame it publishes the
// CRC on crc_out with a single-cycle crc_valid pulse, then reloads INIT.
module crc8_engine #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic [7:0] crc_out,
    output logic       crc_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] crc;
    logic [7:0] crc_next;
    logic [7:0] data;
    logic       last;
    logic [2:0] bit_cnt;
    logic       accept;
    logic       byte_done;

    // One MSB-first CRC step; the x^8 term of the polynomial is implied.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    endfunction

    assign accept    = din_valid && din_ready;
    assign byte_done = (state == SHIFT) && (bit_cnt == 3'd7);
    assign crc_next  = crc_step(crc, data[7]);

    // State register; reset wins over any simultaneous accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a byte takes 8 SHIFT cycles, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (byte_done) begin
                    state_next = last ? DONE : IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs; ready is masked by reset so nothing is offered during it.
    always_comb begin
        busy      = (state != IDLE);
        din_ready = (state == IDLE) && !rst;
    end

    // Byte capture register: only loaded on an accepted byte, shifted in SHIFT.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            data <= din;
            last <= din_last;
        end else if (state == SHIFT) begin
            data <= {data[6:0], 1'b0};
        end
    end

    // CRC register, bit counter and published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc       <= INIT;
            bit_cnt   <= 3'd0;
            crc_out   <= 8'h00;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bit_cnt <= 3'd0;
                    end
                end
                SHIFT: begin
                    crc     <= crc_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done && last) begin
                        crc_out   <= crc_next;
                        crc_valid <= 1'b1;
                    end
                end
                DONE: begin
                    crc <= INIT;
                end
                default: begin
                    crc <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_engine.sv
// Testbench for crc8_engine: table-driven frames, hand-written timing and
// reset sequences, and random frames against a polynomial-division model.
module tb_crc8_engine;

    localparam logic [7:0] POLY = 8'h07;
    localparam logic [7:0] INIT = 8'h00;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        string      name;
        logic [7:0] data[9];
        int         len;
        int         mode;   // 0: valid low while waiting, 1: valid held, 2: noise
        logic [7:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;
    logic [7:0] crc_out;
    logic       crc_valid;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] pulse_crc[$];
    int         pulse_edge[$];
    int         acc_edge[$];
    logic [7:0] held_crc = 8'h00;
    logic       prev_valid = 1'b0;
    logic       rst_q = 1'b1;

    vec_t vecs[7];

    crc8_engine #(.POLY(POLY), .INIT(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .crc_out   (crc_out),
        .crc_valid (crc_valid),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: records every pulse, checks single-cycle pulses and
    // that crc_out holds between pulses (it returns to 0 after a reset edge).
    always @(negedge clk) begin
        check("valid_single", {31'b0, crc_valid & prev_valid}, 32'd0);
        if (rst_q) begin
            held_crc = 8'h00;
        end
        if (crc_valid === 1'b1) begin
            pulse_crc.push_back(crc_out);
            pulse_edge.push_back(cyc);
            held_crc = crc_out;
        end else begin
            check("crc_hold", {24'b0, crc_out}, {24'b0, held_crc});
        end
        prev_valid = crc_valid;
    end

    // Reference: CRC as the remainder of (augmented message) mod P(x), with
    // INIT folded into the leading 8 message bits.
    function automatic logic [7:0] ref_crc(input byte_q_t msg);
        bit         bits[$];
        logic [8:0] p;
        logic [7:0] r;
        p = {1'b1, POLY};
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) bits.push_back(msg[i][b]);
        end
        for (int i = 0; i < 8; i++) bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits[i] = bits[i] ^ INIT[7 - i];
        for (int i = 0; i + 8 < bits.size(); i++) begin
            if (bits[i]) begin
                for (int j = 0; j <= 8; j++) bits[i + j] = bits[i + j] ^ p[8 - j];
            end
        end
        for (int i = 0; i < 8; i++) r[7 - i] = bits[bits.size() - 8 + i];
        return r;
    endfunction

    task automatic send_frame(input byte_q_t msg, input int mode, output bit ok);
        bit got;
        ok = 1'b1;
        for (int i = 0; i < msg.size(); i++) begin
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                @(negedge clk);
                if (din_ready) begin
                    din       = msg[i];
                    din_last  = (i == msg.size() - 1);
                    din_valid = 1'b1;
                    acc_edge.push_back(cyc + 1);
                    @(posedge clk);
                    got = 1'b1;
                end else if (mode == 1) begin
                    din       = msg[i];
                    din_last  = (i == msg.size() - 1);
                    din_valid = 1'b1;
                end else if (mode == 2) begin
                    din       = 8'($urandom);
                    din_last  = 1'($urandom);
                    din_valid = 1'($urandom);
                end else begin
                    din_valid = 1'b0;
                end
            end
            if (!got) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_pulse(input int n0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            din_last  = 1'b0;
            if (pulse_crc.size() > n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input string name, input byte_q_t msg, input int mode,
                             input logic [7:0] exp);
        int n0;
        bit ok;
        bit okp;
        n0 = pulse_crc.size();
        acc_edge.delete();
        send_frame(msg, mode, ok);
        check({name, "_accept_timeout"}, {31'b0, ok}, 32'd1);
        wait_pulse(n0, okp);
        check({name, "_pulse_timeout"}, {31'b0, okp}, 32'd1);
        if (okp && acc_edge.size() > 0) begin
            check({name, "_crc"}, {24'b0, pulse_crc[n0]}, {24'b0, exp});
            check({name, "_latency"}, pulse_edge[n0] - acc_edge[acc_edge.size() - 1], 32'd8);
        end
        if (mode == 1) begin
            for (int i = 1; i < acc_edge.size(); i++)
                check({name, "_byte_spacing"}, acc_edge[i] - acc_edge[i - 1], 32'd9);
        end
        repeat (3) @(negedge clk);
        check({name, "_pulse_count"}, pulse_crc.size(), n0 + 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        byte_q_t q;
        int      n0;
        int      a;
        bit      ok;

        vecs[0] = '{name: "byte01",  data: '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 1, mode: 0, exp: 8'h07};
        vecs[1] = '{name: "byte02",  data: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 1, mode: 0, exp: 8'h0E};
        vecs[2] = '{name: "byte00",  data: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 1, mode: 0, exp: 8'h00};
        vecs[3] = '{name: "byteFF",  data: '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 1, mode: 1, exp: 8'hF3};
        vecs[4] = '{name: "two_byte", data: '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 2, mode: 0, exp: 8'h1B};
        vecs[5] = '{name: "check_str", data: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, len: 9, mode: 1, exp: 8'hF4};
        vecs[6] = '{name: "check_noise", data: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, len: 9, mode: 2, exp: 8'hF4};

        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        din_last  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, din_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, crc_valid}, 32'd0);
        check("rst_crc_out", {24'b0, crc_out}, 32'h00);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, din_ready}, 32'd1);

        // Single byte 0x01 with exact cycle-by-cycle timing
        n0 = pulse_crc.size();
        ok = 1'b0;
        for (int w = 0; w < 10 && !ok; w++) begin
            @(negedge clk);
            if (din_ready) ok = 1'b1;
        end
        check("timing_ready", {31'b0, ok}, 32'd1);
        din = 8'h01; din_last = 1'b1; din_valid = 1'b1;
        a = cyc + 1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            din_valid = 1'b0; din_last = 1'b0; din = 8'h00;
            check("timing_edge", cyc - a, k);
            check("timing_ready_low", {31'b0, din_ready}, 32'd0);
            check("timing_busy", {31'b0, busy}, 32'd1);
            check("timing_valid", {31'b0, crc_valid}, {31'b0, (k == 8)});
        end
        check("timing_crc", {24'b0, crc_out}, 32'h07);
        @(negedge clk);
        check("timing_idle_ready", {31'b0, din_ready}, 32'd1);
        check("timing_idle_busy", {31'b0, busy}, 32'd0);
        check("timing_valid_fell", {31'b0, crc_valid}, 32'd0);
        check("timing_pulses", pulse_crc.size(), n0 + 1);

        // Table-driven frames (back-to-back single-byte frames, held valid, noise)
        for (int v = 0; v < 7; v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].len; i++) q.push_back(vecs[v].data[i]);
            run_frame(vecs[v].name, q, vecs[v].mode, vecs[v].exp);
        end

        // Reset at the 4th SHIFT edge aborts the frame
        n0 = pulse_crc.size();
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (din_ready) ok = 1'b1;
        end
        check("abort_ready", {31'b0, ok}, 32'd1);
        din = 8'h01; din_last = 1'b1; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; din_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready_in_rst", {31'b0, din_ready}, 32'd0);
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_crc_out", {24'b0, crc_out}, 32'h00);
        rst = 1'b0;
        #1;
        check("abort_ready_after", {31'b0, din_ready}, 32'd1);
        repeat (12) @(negedge clk);
        check("abort_no_pulse", pulse_crc.size(), n0);
        check("abort_crc_held", {24'b0, crc_out}, 32'h00);
        q = '{8'h01};
        run_frame("after_abort", q, 0, 8'h07);

        // Reset takes priority over a simultaneous accept
        n0 = pulse_crc.size();
        @(negedge clk);
        din = 8'h55; din_last = 1'b1; din_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("prio_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0; din_valid = 1'b0; din_last = 1'b0;
        #1;
        check("prio_ready", {31'b0, din_ready}, 32'd1);
        repeat (12) @(negedge clk);
        check("prio_no_pulse", pulse_crc.size(), n0);
        check("prio_crc_out", {24'b0, crc_out}, 32'h00);

        // Random frames against the reference model
        for (int f = 0; f < 25; f++) begin
            int len;
            int mode;
            len  = $urandom_range(1, 5);
            mode = $urandom_range(0, 2);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            run_frame("random", q, mode, ref_crc(q));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
